// File: rtl/stack_ctrl.sv
// Command sequencer for the 16x19 hardware stack: PUSH/POP/CALL/RET/INT/RETI with
// atomic capacity checks, sticky overflow/underflow flags and a high-water depth mark.
module stack_ctrl #(
  parameter int unsigned DW       = 19,
  parameter int unsigned SPW      = 4,
  parameter int unsigned SP_EMPTY = 15
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [2:0]     cmd_op,
  input  logic [DW-1:0]  cmd_wdata,
  input  logic [DW-1:0]  cmd_wdata2,
  output logic           rsp_valid,
  output logic           rsp_err,
  output logic [DW-1:0]  rsp_rdata,
  output logic [DW-1:0]  rsp_rdata2,
  output logic           stk_push,
  output logic           stk_pop,
  output logic [DW-1:0]  stk_push_data,
  input  logic [DW-1:0]  stk_pop_data,
  input  logic [SPW-1:0] stk_sp,
  output logic           err_ovf,
  output logic           err_unf,
  input  logic           clr_err,
  output logic [SPW-1:0] max_depth
);

  typedef enum logic [1:0] {S_IDLE, S_OP1, S_OP2, S_RESP} state_t;
  typedef enum logic [2:0] {
    OP_NOP  = 3'd0, OP_PUSH = 3'd1, OP_POP  = 3'd2, OP_CALL = 3'd3,
    OP_RET  = 3'd4, OP_INT  = 3'd5, OP_RETI = 3'd6, OP_RSVD = 3'd7
  } op_t;

  localparam logic [SPW:0] SP_EMPTY_W = (SPW+1)'(SP_EMPTY);
  localparam logic [SPW:0] DEPTH_MAX  = {1'b0, {SPW{1'b1}}};

  state_t          state_q, state_d;
  op_t             op_q, op_d, cmd_op_t;
  logic [DW-1:0]   wdata2_q, wdata2_d;
  logic            err_q, err_d;
  logic            push_d, pop_d, rsp_valid_d, rsp_err_d, cmd_ready_d;
  logic [DW-1:0]   push_data_d, rdata_d, rdata2_d;
  logic            ovf_set, unf_set;
  logic            accept_c, push_type_c, pop_type_c;
  logic [SPW:0]    sp_w, depth_c, need_w;
  logic [SPW-1:0]  depth_sat;

  assign cmd_op_t    = op_t'(cmd_op);
  assign accept_c    = cmd_valid & cmd_ready;
  assign push_type_c = cmd_op_t inside {OP_PUSH, OP_CALL, OP_INT};
  assign pop_type_c  = cmd_op_t inside {OP_POP, OP_RET, OP_RETI};
  assign need_w      = (cmd_op_t inside {OP_INT, OP_RETI}) ? (SPW+1)'(2) : (SPW+1)'(1);

  // Free slots equal sp; occupied entries equal SP_EMPTY - sp.
  assign sp_w      = {1'b0, stk_sp};
  assign depth_c   = (sp_w > SP_EMPTY_W) ? '0 : SP_EMPTY_W - sp_w;
  assign depth_sat = (depth_c > DEPTH_MAX) ? {SPW{1'b1}} : depth_c[SPW-1:0];

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    wdata2_d    = wdata2_q;
    err_d       = err_q;
    push_d      = 1'b0;
    pop_d       = 1'b0;
    push_data_d = '0;
    rdata_d     = rsp_rdata;
    rdata2_d    = rsp_rdata2;
    ovf_set     = 1'b0;
    unf_set     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          op_d     = cmd_op_t;
          wdata2_d = cmd_wdata2;
          rdata_d  = '0;
          rdata2_d = '0;
          err_d    = 1'b0;
          if (push_type_c && (sp_w < need_w)) begin
            err_d   = 1'b1;
            ovf_set = 1'b1;
            state_d = S_RESP;
          end else if (pop_type_c && (depth_c < need_w)) begin
            err_d   = 1'b1;
            unf_set = 1'b1;
            state_d = S_RESP;
          end else if (push_type_c) begin
            push_d      = 1'b1;
            push_data_d = cmd_wdata;
            state_d     = S_OP1;
          end else if (pop_type_c) begin
            pop_d   = 1'b1;
            state_d = S_OP1;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_OP1: begin
        state_d = S_RESP;
        if (op_q == OP_INT) begin
          push_d      = 1'b1;
          push_data_d = wdata2_q;
          state_d     = S_OP2;
        end else if (op_q == OP_RETI) begin
          pop_d    = 1'b1;
          rdata2_d = stk_pop_data;
          state_d  = S_OP2;
        end else if (op_q inside {OP_POP, OP_RET}) begin
          rdata_d = stk_pop_data;
        end
      end
      S_OP2: begin
        if (op_q == OP_RETI) rdata_d = stk_pop_data;
        state_d = S_RESP;
      end
      S_RESP: state_d = S_IDLE;
    endcase
    rsp_valid_d = (state_d == S_RESP);
    rsp_err_d   = (state_d == S_RESP) & err_d;
    cmd_ready_d = (state_d == S_IDLE);
  end

  // Strobes and response fields are registered from the next-state decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      op_q          <= OP_NOP;
      wdata2_q      <= '0;
      err_q         <= 1'b0;
      cmd_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_err       <= 1'b0;
      rsp_rdata     <= '0;
      rsp_rdata2    <= '0;
      stk_push      <= 1'b0;
      stk_pop       <= 1'b0;
      stk_push_data <= '0;
      err_ovf       <= 1'b0;
      err_unf       <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      wdata2_q      <= wdata2_d;
      err_q         <= err_d;
      cmd_ready     <= cmd_ready_d;
      rsp_valid     <= rsp_valid_d;
      rsp_err       <= rsp_err_d;
      rsp_rdata     <= rdata_d;
      rsp_rdata2    <= rdata2_d;
      stk_push      <= push_d;
      stk_pop       <= pop_d;
      stk_push_data <= push_data_d;
      err_ovf       <= clr_err ? 1'b0 : (err_ovf | ovf_set);
      err_unf       <= clr_err ? 1'b0 : (err_unf | unf_set);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       max_depth <= '0;
    else if (depth_sat > max_depth)  max_depth <= depth_sat;
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with a behavioural 16x19 stack attached.
module tb_stack_ctrl;
  localparam int unsigned DW = 19;
  localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, CALL = 3'd3,
                         RET = 3'd4, INT = 3'd5, RETI = 3'd6;

  logic          clk = 1'b0, reset = 1'b1;
  logic          cmd_valid = 1'b0, cmd_ready, clr_err = 1'b0;
  logic [2:0]    cmd_op = 3'd0;
  logic [DW-1:0] cmd_wdata = '0, cmd_wdata2 = '0;
  logic          rsp_valid, rsp_err, stk_push, stk_pop, err_ovf, err_unf;
  logic [DW-1:0] rsp_rdata, rsp_rdata2, stk_push_data, stk_pop_data;
  logic [3:0]    stk_sp, max_depth;

  int vectors = 0, miscompares = 0;
  int push_cnt = 0, rv_cnt = 0, overlap_cnt = 0;
  logic [DW-1:0] last_push = '0, prev_push = '0;
  logic [DW-1:0] mem [16];

  stack_ctrl dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_wdata(cmd_wdata), .cmd_wdata2(cmd_wdata2),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .rsp_rdata2(rsp_rdata2), .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_push_data(stk_push_data), .stk_pop_data(stk_pop_data), .stk_sp(stk_sp),
    .err_ovf(err_ovf), .err_unf(err_unf), .clr_err(clr_err), .max_depth(max_depth)
  );

  always #5 clk = ~clk;

  // Stack model: push pre-decrements, top of stack is mem[sp], shares the reset net.
  initial for (int i = 0; i < 16; i++) mem[i] = '0;
  always @(posedge clk or posedge reset) begin
    if (reset) stk_sp <= 4'd15;
    else if (stk_push && stk_sp != 4'd0) begin
      mem[stk_sp - 4'd1] <= stk_push_data;
      stk_sp <= stk_sp - 4'd1;
    end else if (stk_pop && stk_sp < 4'd15) stk_sp <= stk_sp + 4'd1;
  end
  assign stk_pop_data = mem[stk_sp];

  always @(posedge clk) begin
    if (stk_push) begin
      push_cnt  <= push_cnt + 1;
      prev_push <= last_push;
      last_push <= stk_push_data;
    end
    if (rsp_valid) rv_cnt <= rv_cnt + 1;
    if (stk_push && stk_pop) overlap_cnt <= overlap_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one command in IDLE, then count cycles from the accept edge to rsp_valid.
  task automatic issue(input logic [2:0] op, input logic [DW-1:0] wd,
                       input logic [DW-1:0] wd2, output int lat);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_wdata = wd; cmd_wdata2 = wd2;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = NOP;
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; cmd_valid = 1'b0; clr_err = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    int lat, pc0, rv0;
    logic any_err;
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, pc0, rv0;
    logic any_err;
    // Reset state
    @(posedge clk); #1;
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_outs", {26'd0, rsp_valid, rsp_err, stk_push, stk_pop, err_ovf, err_unf}, 32'd0);
    chk("rst_maxd", 32'(max_depth), 32'd0);
    reset = 1'b0;

    // 1: three pushes, three pops in LIFO order
    issue(PUSH, 19'h11, '0, lat); chk("t1_push_lat", 32'(lat), 32'd2);
    chk("t1_push_err", 32'(rsp_err), 32'd0);
    issue(PUSH, 19'h22, '0, lat);
    issue(CALL, 19'h33, '0, lat); chk("t1_call_lat", 32'(lat), 32'd2);
    chk("t1_sp3", 32'(stk_sp), 32'd12);
    issue(POP, '0, '0, lat); chk("t1_pop1", 32'(rsp_rdata), 32'h33);
    chk("t1_pop_lat", 32'(lat), 32'd2);
    issue(RET, '0, '0, lat); chk("t1_pop2", 32'(rsp_rdata), 32'h22);
    issue(POP, '0, '0, lat); chk("t1_pop3", 32'(rsp_rdata), 32'h11);
    chk("t1_flags", {30'd0, err_ovf, err_unf}, 32'd0);
    chk("t1_maxd", 32'(max_depth), 32'd3);
    issue(NOP, '0, '0, lat); chk("nop_lat", 32'(lat), 32'd1);
    chk("nop_err", 32'(rsp_err), 32'd0);

    // 2: fill to sp=0, then one more push is rejected
    any_err = 1'b0;
    for (int i = 0; i < 15; i++) begin
      issue(PUSH, 19'(i + 1), '0, lat);
      any_err |= rsp_err;
    end
    chk("t2_fill_err", 32'(any_err), 32'd0);
    chk("t2_sp0", 32'(stk_sp), 32'd0);
    pc0 = push_cnt;
    issue(PUSH, 19'h7, '0, lat);
    chk("t2_ovf_lat", 32'(lat), 32'd1);
    chk("t2_rsp_err", 32'(rsp_err), 32'd1);
    chk("t2_err_ovf", 32'(err_ovf), 32'd1);
    chk("t2_sp_kept", 32'(stk_sp), 32'd0);
    chk("t2_no_push", 32'(push_cnt), 32'(pc0));
    chk("t2_maxd", 32'(max_depth), 32'd15);

    // 3: underflow on empty stack, then clear
    do_reset();
    chk("t3_maxd_rst", 32'(max_depth), 32'd0);
    issue(RET, '0, '0, lat);
    chk("t3_unf_lat", 32'(lat), 32'd1);
    chk("t3_rsp_err", 32'(rsp_err), 32'd1);
    chk("t3_err_unf", 32'(err_unf), 32'd1);
    @(posedge clk); #1; clr_err = 1'b1;
    @(posedge clk); #1; clr_err = 1'b0;
    chk("t3_clr", {30'd0, err_ovf, err_unf}, 32'd0);

    // 4: interrupt entry pushes PC then flags; RETI restores both
    pc0 = push_cnt;
    issue(INT, 19'h00100, 19'h5, lat);
    chk("t4_int_lat", 32'(lat), 32'd3);
    chk("t4_int_err", 32'(rsp_err), 32'd0);
    chk("t4_pushes", 32'(push_cnt - pc0), 32'd2);
    chk("t4_push_pc", 32'(prev_push), 32'h100);
    chk("t4_push_fl", 32'(last_push), 32'h5);
    chk("t4_sp13", 32'(stk_sp), 32'd13);
    issue(RETI, '0, '0, lat);
    chk("t4_reti_lat", 32'(lat), 32'd3);
    chk("t4_rdata2", 32'(rsp_rdata2), 32'h5);
    chk("t4_rdata", 32'(rsp_rdata), 32'h100);
    chk("t4_sp15", 32'(stk_sp), 32'd15);

    // 5: one free slot, INT needs two -> rejected atomically
    for (int i = 0; i < 14; i++) issue(PUSH, 19'(i + 32), '0, lat);
    chk("t5_sp1", 32'(stk_sp), 32'd1);
    pc0 = push_cnt;
    issue(INT, 19'h200, 19'h3, lat);
    chk("t5_lat", 32'(lat), 32'd1);
    chk("t5_rsp_err", 32'(rsp_err), 32'd1);
    chk("t5_sp_kept", 32'(stk_sp), 32'd1);
    chk("t5_no_push", 32'(push_cnt), 32'(pc0));
    chk("t5_err_ovf", 32'(err_ovf), 32'd1);

    // 6: reset while INT is in its second push
    do_reset();
    cmd_valid = 1'b1; cmd_op = INT; cmd_wdata = 19'h300; cmd_wdata2 = 19'h1;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = NOP;
    @(posedge clk); #1;
    chk("t6_in_op2", 32'(stk_push), 32'd1);
    rv0 = rv_cnt;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t6_ready", 32'(cmd_ready), 32'd1);
    chk("t6_sp15", 32'(stk_sp), 32'd15);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("t6_no_rsp", 32'(rv_cnt), 32'(rv0));
    chk("t6_idle", 32'(cmd_ready), 32'd1);
    chk("push_pop_excl", 32'(overlap_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
